bandit_agent: RTL and testbench

Parametrised epsilon-greedy multi-armed bandit agent: successor to the fixed 256-arm, 8-bit `bandit`. Keeps a table of per-action value estimates, offers one action per trial on a valid/ready stream, accepts a reward on a second stream, and applies an exponential-moving-average update with programmable step. Adds an LFSR-driven exploration mode, self-clearing of the table after reset, and configurable arm count and widths.

---
 rtl/bandit_pkg.sv | 38 +++
 rtl/bandit_lfsr.sv | 25 ++
 rtl/bandit_agent.sv | 183 ++++++++++++++++++
 tb/tb_bandit_agent.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bandit_pkg.sv
// Shared definitions for the epsilon-greedy bandit agent.
// Contents: controller state encoding, the Galois LFSR tap mask, and the
// exponential-moving-average value update helper.
package bandit_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_DECIDE = 3'd1,
        ST_SCAN   = 3'd2,
        ST_OFFER  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_READ   = 3'd5,
        ST_WRITE  = 3'd6
    } bandit_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Q + (((R << frac) - Q) >>> step), computed signed with headroom so the
    // difference never wraps. The result always lies between Q and R << frac,
    // so the caller can truncate it back to the table width without loss.
    function automatic logic [31:0] update_value(
        input logic [31:0] q,
        input logic [31:0] r,
        input int unsigned frac,
        input int unsigned step
    );
        logic signed [33:0] q_s;
        logic signed [33:0] target_s;
        logic signed [33:0] diff_s;
        logic signed [33:0] res_s;
        q_s      = $signed({2'b00, q});
        target_s = $signed({2'b00, r}) <<< frac;
        diff_s   = target_s - q_s;
        res_s    = q_s + (diff_s >>> step);
        return res_s[31:0];
    endfunction

endpackage

// File: rtl/bandit_lfsr.sv
// 16-bit Galois LFSR, right-shifting every clock outside reset.
// Ports: clock (rising edge), reset (async, active-low),
//        value (current register contents, SEED while in reset).
module bandit_lfsr
    import bandit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] value
);

    // LFSR state register; the tap mask is folded in when bit 0 shifts out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= SEED;
        end else if (value[0]) begin
            value <= (value >> 1) ^ LFSR_TAPS;
        end else begin
            value <= value >> 1;
        end
    end

endmodule

// File: rtl/bandit_agent.sv
// Epsilon-greedy multi-armed bandit agent.
// Keeps an ACTIONS x VALUE_WIDTH value table, offers one action per trial on
// the action stream (random arm when exploring, argmax otherwise), accepts a
// reward on the reward stream and applies an EMA update to the chosen entry.
// Ports: clock, reset (async active-low);
//        action_valid/action_data/action_explore out, action_ready in;
//        reward_valid/reward_data in, reward_ready out.
module bandit_agent
    import bandit_pkg::*;
#(
    parameter int          ACTIONS      = 256,
    parameter int          ACTION_WIDTH = $clog2(ACTIONS),
    parameter int          REWARD_WIDTH = 8,
    parameter int          VALUE_WIDTH  = 16,
    parameter int          STEP_SHIFT   = 3,
    parameter int          EPSILON      = 26,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    action_valid,
    output logic [ACTION_WIDTH-1:0] action_data,
    output logic                    action_explore,
    input  logic                    action_ready,
    input  logic                    reward_valid,
    input  logic [REWARD_WIDTH-1:0] reward_data,
    output logic                    reward_ready
);

    localparam int FRAC = VALUE_WIDTH - REWARD_WIDTH;
    localparam logic [ACTION_WIDTH:0] CNT_LAST = (ACTION_WIDTH+1)'(ACTIONS - 1);
    localparam logic [ACTION_WIDTH:0] CNT_END  = (ACTION_WIDTH+1)'(ACTIONS);
    localparam logic [ACTION_WIDTH:0] CNT_ONE  = (ACTION_WIDTH+1)'(1);
    localparam logic [7:0]            EPS_TH   = 8'(EPSILON);

    bandit_state_e           state_r;
    logic [ACTION_WIDTH:0]   cnt_r;
    logic [REWARD_WIDTH-1:0] reward_r;
    logic [VALUE_WIDTH-1:0]  best_val_r;
    logic [ACTION_WIDTH-1:0] best_idx_r;

    logic [VALUE_WIDTH-1:0]  mem_r [ACTIONS];
    logic [VALUE_WIDTH-1:0]  rd_data_r;

    logic [15:0]             lfsr_s;
    logic [ACTION_WIDTH-1:0] ram_addr_s;
    logic                    ram_we_s;
    logic [VALUE_WIDTH-1:0]  ram_wdata_s;
    logic [ACTION_WIDTH:0]   prev_cnt_s;
    logic [ACTION_WIDTH-1:0] prev_idx_s;
    logic                    take_s;

    bandit_lfsr #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_s)
    );

    // SCAN compare: data returned this cycle belongs to index cnt_r-1; the
    // first returned entry seeds the running max, later ones need strict >.
    always_comb begin
        prev_cnt_s = cnt_r - CNT_ONE;
        prev_idx_s = prev_cnt_s[ACTION_WIDTH-1:0];
        if (cnt_r == CNT_ONE) begin
            take_s = 1'b1;
        end else begin
            take_s = (rd_data_r > best_val_r);
        end
    end

    // Table port control: clear writes, scan/update reads, update write-back.
    always_comb begin
        ram_addr_s  = '0;
        ram_we_s    = 1'b0;
        ram_wdata_s = '0;
        case (state_r)
            ST_CLEAR: begin
                ram_addr_s = cnt_r[ACTION_WIDTH-1:0];
                ram_we_s   = 1'b1;
            end
            ST_SCAN: begin
                ram_addr_s = cnt_r[ACTION_WIDTH-1:0];
            end
            ST_READ: begin
                ram_addr_s = action_data;
            end
            ST_WRITE: begin
                ram_addr_s  = action_data;
                ram_we_s    = 1'b1;
                ram_wdata_s = VALUE_WIDTH'(update_value(32'(rd_data_r), 32'(reward_r),
                                                        FRAC, STEP_SHIFT));
            end
            default: begin
                ram_addr_s = '0;
            end
        endcase
    end

    // Value table: synchronous-read RAM, intentionally without reset.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            mem_r[ram_addr_s] <= ram_wdata_s;
        end
        rd_data_r <= mem_r[ram_addr_s];
    end

    // Trial controller with registered stream outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_CLEAR;
            cnt_r          <= '0;
            reward_r       <= '0;
            best_val_r     <= '0;
            best_idx_r     <= '0;
            action_valid   <= 1'b0;
            action_data    <= '0;
            action_explore <= 1'b0;
            reward_ready   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_DECIDE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DECIDE: begin
                    cnt_r <= '0;
                    if (lfsr_s[7:0] < EPS_TH) begin
                        action_data    <= lfsr_s[8 +: ACTION_WIDTH];
                        action_explore <= 1'b1;
                        action_valid   <= 1'b1;
                        state_r        <= ST_OFFER;
                    end else begin
                        action_explore <= 1'b0;
                        state_r        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if ((cnt_r != '0) && take_s) begin
                        best_val_r <= rd_data_r;
                        best_idx_r <= prev_idx_s;
                    end
                    if (cnt_r == CNT_END) begin
                        action_data  <= take_s ? prev_idx_s : best_idx_r;
                        action_valid <= 1'b1;
                        state_r      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (action_ready) begin
                        action_valid <= 1'b0;
                        reward_ready <= 1'b1;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (reward_valid) begin
                        reward_r     <= reward_data;
                        reward_ready <= 1'b0;
                        state_r      <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_r <= ST_WRITE;
                end
                ST_WRITE: begin
                    state_r <= ST_DECIDE;
                end
                default: begin
                    action_valid <= 1'b0;
                    reward_ready <= 1'b0;
                    cnt_r        <= '0;
                    state_r      <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bandit_agent.sv
// Self-checking bench for bandit_agent: three 4-arm instances
//   a: 8-bit values, step 1/2, pure greedy
//   b: 16-bit values, step 1, pure greedy (saturation)
//   c: 16-bit values, step 1/4, epsilon 128/256 (mixed explore/greedy)
// compared against a trial-level model (value array, argmax, LFSR sequence).
module tb_bandit_agent;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       av [3];
    logic       ax [3];
    logic       ar [3];
    logic       rv [3];
    logic       rr [3];
    logic [1:0] ad [3];
    logic [7:0] rd [3];

    int errors = 0;
    int checks = 0;
    int cyc;

    int vw  [3] = '{8, 16, 16};
    int ss  [3] = '{1, 0, 2};
    int eps [3] = '{0, 0, 128};
    int mq  [3][4];
    int dec_cyc [3];

    bandit_agent #(.ACTIONS(4), .REWARD_WIDTH(8), .VALUE_WIDTH(8),
                   .STEP_SHIFT(1), .EPSILON(0)) dut_a (
        .clock(clock), .reset(reset),
        .action_valid(av[0]), .action_data(ad[0]), .action_explore(ax[0]),
        .action_ready(ar[0]), .reward_valid(rv[0]), .reward_data(rd[0]),
        .reward_ready(rr[0]));

    bandit_agent #(.ACTIONS(4), .REWARD_WIDTH(8), .VALUE_WIDTH(16),
                   .STEP_SHIFT(0), .EPSILON(0)) dut_b (
        .clock(clock), .reset(reset),
        .action_valid(av[1]), .action_data(ad[1]), .action_explore(ax[1]),
        .action_ready(ar[1]), .reward_valid(rv[1]), .reward_data(rd[1]),
        .reward_ready(rr[1]));

    bandit_agent #(.ACTIONS(4), .REWARD_WIDTH(8), .VALUE_WIDTH(16),
                   .STEP_SHIFT(2), .EPSILON(128), .SEED(16'hACE1)) dut_c (
        .clock(clock), .reset(reset),
        .action_valid(av[2]), .action_data(ad[2]), .action_explore(ax[2]),
        .action_ready(ar[2]), .reward_valid(rv[2]), .reward_data(rd[2]),
        .reward_ready(rr[2]));

    // Cycle number since reset release; cycle 0 ends at the first active edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // LFSR contents during cycle n after reset release.
    function automatic int lfsr_at(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            if (l[0]) l = (l >> 1) ^ 16'hB400;
            else      l = l >> 1;
        end
        return int'(l);
    endfunction

    function automatic int argmax(input int k);
        int best;
        best = 0;
        for (int i = 1; i < 4; i++) if (mq[k][i] > mq[k][best]) best = i;
        return best;
    endfunction

    function automatic int read_q(input int k, input int i);
        case (k)
            0:       return int'(dut_a.mem_r[i]);
            1:       return int'(dut_b.mem_r[i]);
            default: return int'(dut_c.mem_r[i]);
        endcase
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            dec_cyc[k] = 4;
            for (int i = 0; i < 4; i++) mq[k][i] = 0;
        end
    endtask

    // One full trial on instance k; entered at a negedge.
    task automatic run_trial(input int k, input int reward, input int bp, input int rdelay);
        int  l, exp_a, exp_rise, n, w, target, d;
        bit  exp_x, timed;
        logic [1:0] ad0;
        logic ax0;
        l        = lfsr_at(dec_cyc[k]);
        exp_x    = (l & 255) < eps[k];
        exp_a    = exp_x ? ((l >> 8) & 3) : argmax(k);
        exp_rise = dec_cyc[k] + (exp_x ? 1 : 6);
        timed    = (cyc < exp_rise);
        n = 0;
        while (!av[k] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            check_eq($sformatf("valid_timeout%0d", k), 0, 1);
            return;
        end
        if (timed) check_eq($sformatf("rise_cycle%0d", k), cyc, exp_rise);
        check_eq($sformatf("action%0d", k), ad[k], exp_a);
        check_eq($sformatf("explore%0d", k), ax[k], exp_x);
        ad0 = ad[k];
        ax0 = ax[k];
        for (int i = 0; i < bp; i++) begin
            @(negedge clock);
            check_eq($sformatf("bp_valid%0d", k), av[k], 1);
            check_eq($sformatf("bp_data%0d", k), ad[k], ad0);
            check_eq($sformatf("bp_explore%0d", k), ax[k], ax0);
            check_eq($sformatf("bp_rready%0d", k), rr[k], 0);
        end
        ar[k] = 1'b1;
        @(posedge clock);
        #1 ar[k] = 1'b0;
        @(negedge clock);
        check_eq($sformatf("rready_rise%0d", k), rr[k], 1);
        check_eq($sformatf("valid_fall%0d", k), av[k], 0);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clock);
            check_eq($sformatf("rready_hold%0d", k), rr[k], 1);
        end
        rd[k] = 8'(reward);
        rv[k] = 1'b1;
        w = cyc;
        @(negedge clock);
        rv[k] = 1'b0;
        check_eq($sformatf("rready_fall%0d", k), rr[k], 0);
        target = reward << (vw[k] - 8);
        d = target - mq[k][exp_a];
        mq[k][exp_a] = mq[k][exp_a] + (d >>> ss[k]);
        dec_cyc[k] = w + 3;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("q%0d_%0d", k, i), read_q(k, i), mq[k][i]);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            ar[k] = 1'b0;
            rv[k] = 1'b0;
            rd[k] = 8'd0;
        end
        reset_model();
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_valid%0d", k), av[k], 0);
            check_eq($sformatf("rst_data%0d", k), ad[k], 0);
            check_eq($sformatf("rst_explore%0d", k), ax[k], 0);
            check_eq($sformatf("rst_rready%0d", k), rr[k], 0);
        end
        reset = 1'b1;

        // Greedy update: 100 -> 50, then 0 -> 25, then random rewards.
        run_trial(0, 100, 0, 0);
        run_trial(0, 0, 5, 1);
        for (int t = 0; t < 6; t++)
            run_trial(0, $urandom_range(255, 0), $urandom_range(3, 0), $urandom_range(2, 0));

        // Saturation at full-scale reward with unit step.
        for (int t = 0; t < 10; t++)
            run_trial(1, 255, $urandom_range(2, 0), 0);
        check_eq("sat_q0", read_q(1, 0), 32'hFF00);

        // Mixed exploration against the LFSR model.
        for (int t = 0; t < 20; t++)
            run_trial(2, $urandom_range(255, 0), $urandom_range(3, 0), $urandom_range(2, 0));

        // Reset while waiting for a reward.
        while (!av[0]) @(negedge clock);
        ar[0] = 1'b1;
        @(posedge clock);
        #1 ar[0] = 1'b0;
        @(negedge clock);
        check_eq("wait_rready", rr[0], 1);
        rd[0] = 8'd200;
        rv[0] = 1'b1;
        reset = 1'b0;
        #1;
        check_eq("rst_wait_rready", rr[0], 0);
        check_eq("rst_wait_valid", av[0], 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        reset_model();
        repeat (4) @(negedge clock);
        rv[0] = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("clr_q%0d_%0d", k, i), read_q(k, i), 0);
        run_trial(0, 60, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
